vga_sync_gen: RTL and testbench

//  Drives the pixel raster the game renderer consumes. Generates x/y pixel coordinates, video_on and a

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_sync_gen.sv | 80 ++++++++
 tb/tb_vga_sync_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, shared by the sync generator and the
// renderers' bounds checks.
package vga_timing_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_ACTIVE_LOW = 1'b0;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with terminal-count wrap, active-area
// flag and polarity-applied raw sync.
module vga_axis_counter #(
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter logic POL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       active,
    output logic       sync_raw
);
    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    // 11-bit compares so a window ending at 1024 is still representable.
    logic [10:0] cnt_x;
    assign cnt_x = {1'b0, cnt};

    assign wrap     = en && (cnt_x == 11'(TOTAL - 1));
    assign active   = cnt_x < 11'(ACTIVE);
    assign sync_raw = (cnt_x >= 11'(SYNC_START) && cnt_x < 11'(SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 10'd1;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel-rate divider, h/v counters, and one aligned
// output stage for colour and sync pins.
module vga_sync_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_ACTIVE_LOW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        pixel_tick,
    output logic        frame_tick,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             h_wrap, v_wrap_unused;
    logic             h_active, v_active;
    logic             hs_raw, vs_raw;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div_cnt    <= div_last ? '0 : div_cnt + DIV_W'(1);
            pixel_tick <= div_last;
        end
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst(rst), .en(pixel_tick),
        .cnt(x), .wrap(h_wrap), .active(h_active), .sync_raw(hs_raw)
    );

    // h_wrap is already qualified by pixel_tick inside the counter.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst(rst), .en(pixel_tick & h_wrap),
        .cnt(y), .wrap(v_wrap_unused), .active(v_active), .sync_raw(vs_raw)
    );

    assign video_on   = h_active & v_active;
    assign frame_tick = pixel_tick && (x == 10'd0) && (y == 10'(V_ACTIVE));

    // Colour and sync share this stage so the pin timing of each pixel
    // lines up exactly with its sync state.
    always_ff @(posedge clk) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            hsync                 <= ~SYNC_POL;
            vsync                 <= ~SYNC_POL;
        end else if (pixel_tick) begin
            {vga_r, vga_g, vga_b} <= video_on ? rgb_in : 12'h000;
            hsync                 <= hs_raw;
            vsync                 <= vs_raw;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (25x15), at CLK_DIV=4 and CLK_DIV=1.
module tb_vga_sync_gen;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3, HT = HA + HFP + HS + HBP;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        ptick;
        logic        ftick;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]  x4, y4, x1, y1;
    logic        von4, ptick4, ftick4, hs4, vs4;
    logic        von1, ptick1, ftick1, hs1, vs1;
    logic [3:0]  r4, g4, b4, r1, g1, b1;
    logic [11:0] rgb4, rgb1;

    // Renderer model: colour is a combinational function of the coordinates.
    assign rgb4 = {x4[3:0], y4[3:0], 4'hA};
    assign rgb1 = {x1[3:0], y1[3:0], 4'hA};

    vga_sync_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut4 (
        .clk(clk), .rst(rst), .rgb_in(rgb4), .x(x4), .y(y4), .video_on(von4),
        .pixel_tick(ptick4), .frame_tick(ftick4), .vga_r(r4), .vga_g(g4), .vga_b(b4),
        .hsync(hs4), .vsync(vs4)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .rgb_in(rgb1), .x(x1), .y(y1), .video_on(von1),
        .pixel_tick(ptick1), .frame_tick(ftick1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .hsync(hs1), .vsync(vs1)
    );

    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    obs_t q4[$];
    obs_t q1[$];

    // Closed-form expectation after the k-th clock edge since reset (k=0: in reset).
    function automatic obs_t model(int kk, int d);
        obs_t o;
        int pix, q, qx, qy;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        pix = (kk >= 1) ? ((kk - 1) / d) % FT : 0;
        o.x = 10'(pix % HT);
        o.y = 10'(pix / HT);
        o.von = ((pix % HT) < HA) && ((pix / HT) < VA);
        o.ptick = (kk >= d) && (kk % d == 0);
        o.ftick = o.ptick && (pix == VA * HT);
        q = (kk >= 1) ? (kk - 1) / d - 1 : -1;
        if (q >= 0) begin
            q  = q % FT;
            qx = q % HT;
            qy = q / HT;
            o.hs  = !(qx >= HA + HFP && qx < HA + HFP + HS);
            o.vs  = !(qy >= VA + VFP && qy < VA + VFP + VS);
            o.rgb = (qx < HA && qy < VA) ? {4'(qx), 4'(qy), 4'hA} : 12'h000;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        obs_t e4, e1, o4, o1;
        @(posedge clk);
        k = rst ? 0 : k + 1;
        q4.push_back(model(k, 4));
        q1.push_back(model(k, 1));
        #1;
        o4 = {x4, y4, von4, ptick4, ftick4, r4, g4, b4, hs4, vs4};
        o1 = {x1, y1, von1, ptick1, ftick1, r1, g1, b1, hs1, vs1};
        e4 = q4.pop_front();
        e1 = q1.pop_front();
        checks++;
        assert (o4 === e4) else begin
            failures++;
            $error("FAIL sb_div4 k=%0d observed=%h expected=%h", k, o4, e4);
        end
        checks++;
        assert (o1 === e1) else begin
            failures++;
            $error("FAIL sb_div1 k=%0d observed=%h expected=%h", k, o1, e1);
        end
    endtask

    initial begin
        logic [20:0] tmask, emask;
        int hs_low, vs_low, hs_first, ft_n, ft1_n, p1_cnt, ft_after, ft_after_k;
        int ft_k[2];
        int ft1_k[2];
        tmask = '0; emask = '0;
        hs_low = 0; vs_low = 0; hs_first = -1; ft_n = 0; ft1_n = 0; p1_cnt = 0;
        ft_k = '{0, 0}; ft1_k = '{0, 0};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_div_cnt4", 32'(dut4.div_cnt), 0);
        chk("rst_pins4", {hs4, vs4, r4, g4, b4}, {2'b11, 12'h000});
        rst = 1'b0;

        for (int i = 1; i <= 3000; i++) begin
            step();
            if (i <= 20) begin
                tmask[i] = ptick4;
                emask[i] = (i % 4 == 0);
            end
            if (!hs4) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (!vs4) vs_low++;
            if (ftick4) begin
                if (ft_n < 2) ft_k[ft_n] = i;
                ft_n++;
                chk("ftick_xy", {x4, y4}, {10'd0, 10'(VA)});
            end
            if (ftick1) begin
                if (ft1_n < 2) ft1_k[ft1_n] = i;
                ft1_n++;
            end
            if (ptick1) p1_cnt++;
            if (i == 4)   chk("first_tick_x", {ptick4, x4}, {1'b1, 10'd0});
            if (i == 5)   chk("x_after_tick", x4, 1);
            if (i == 100) chk("line_end_xy", {x4, y4}, {10'(HT - 1), 10'd0});
            if (i == 101) chk("line_wrap_xy", {x4, y4}, {10'd0, 10'd1});
            if (i == 4 * (7 * HT + 5) + 5)  chk("rgb_5_7", {r4, g4, b4}, 12'h57A);
            if (i == 4 * (7 * HT + HA) + 5) chk("rgb_hblank", {r4, g4, b4}, 12'h000);
            if (i == 4 * (VA * HT + 5) + 5) chk("rgb_vblank", {r4, g4, b4}, 12'h000);
        end

        chk("tick_mask", 32'(tmask), 32'(emask));
        chk("ftick_count", ft_n, 2);
        chk("ftick_first", ft_k[0], 4 * (VA * HT + 1));
        chk("ftick_period", ft_k[1] - ft_k[0], 4 * FT);
        chk("hs_first_low", hs_first, 4 * (HA + HFP) + 5);
        chk("hs_low_clks", hs_low, 2 * VT * HS * 4);
        chk("vs_low_clks", vs_low, 2 * VS * HT * 4);
        chk("div1_ticks", p1_cnt, 3000);
        chk("div1_ftick_first", ft1_k[0], VA * HT + 1);
        chk("div1_ftick_period", ft1_k[1] - ft1_k[0], FT);

        // Mid-frame reset at (10,5) of the third frame.
        while (k < 4 * (2 * FT + 5 * HT + 10) + 2) step();
        chk("pre_rst_xy", {x4, y4}, {10'd10, 10'd5});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_xy", {x4, y4, x1, y1}, 40'd0);
        chk("mid_rst_div", {30'd0, dut4.div_cnt}, 0);
        ft_after = 0; ft_after_k = 0;
        for (int i = 1; i <= 900; i++) begin
            step();
            if (ftick4) begin
                if (ft_after == 0) ft_after_k = i;
                ft_after++;
            end
        end
        chk("post_rst_ftick_count", ft_after, 1);
        chk("post_rst_ftick_k", ft_after_k, 4 * (VA * HT + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
